// File: rtl/status_sender.sv
// Status packet builder for the FT245 TX FIFO.
// Counts receiver events and streams a 14-byte snapshot packet.
module status_sender #(
  parameter int          DATA_W       = 8,
  parameter int          NUM_CHANNELS = 128,
  parameter logic [15:0] FW_VERSION   = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              clear_counts,
  input  logic              read_error,
  input  logic              phase_parse_en,
  input  logic              mod_enable,
  input  logic [15:0]       mod_half_period,
  input  logic              txfifo_full,
  output logic              txfifo_wr,
  output logic [DATA_W-1:0] txfifo_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  localparam logic [15:0] NCH = 16'(NUM_CHANNELS);
  localparam logic [3:0]  LAST_IDX = 4'd13;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  idx;
  logic        pending;
  logic [15:0] err_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] snap_err;
  logic [15:0] snap_frm;
  logic [15:0] snap_mhp;
  logic        snap_en;
  logic [7:0]  snap_chk;
  logic [7:0]  chk_live;
  logic [7:0]  byte_sel;
  logic        last_wr;

  assign last_wr = txfifo_wr && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req || pending) state_nx = LOAD;
      LOAD: state_nx = SEND;
      SEND: if (last_wr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    txfifo_wr   = (state == SEND) && !txfifo_full;
    busy        = (state != IDLE);
    txfifo_data = '0;
    if (state == SEND) txfifo_data = byte_sel;
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (idx)
      4'd0:  byte_sel = 8'hA5;
      4'd1:  byte_sel = 8'h5A;
      4'd2:  byte_sel = FW_VERSION[15:8];
      4'd3:  byte_sel = FW_VERSION[7:0];
      4'd4:  byte_sel = NCH[15:8];
      4'd5:  byte_sel = NCH[7:0];
      4'd6:  byte_sel = snap_err[15:8];
      4'd7:  byte_sel = snap_err[7:0];
      4'd8:  byte_sel = snap_frm[15:8];
      4'd9:  byte_sel = snap_frm[7:0];
      4'd10: byte_sel = {7'b0, snap_en};
      4'd11: byte_sel = snap_mhp[15:8];
      4'd12: byte_sel = snap_mhp[7:0];
      4'd13: byte_sel = snap_chk;
      default: byte_sel = 8'h00;
    endcase
  end

  // Checksum over bytes 2..12, formed from the values being snapshotted
  always_comb begin
    chk_live = FW_VERSION[15:8] ^ FW_VERSION[7:0]
             ^ NCH[15:8] ^ NCH[7:0]
             ^ err_cnt[15:8] ^ err_cnt[7:0]
             ^ frame_cnt[15:8] ^ frame_cnt[7:0]
             ^ {7'b0, mod_enable}
             ^ mod_half_period[15:8]
             ^ mod_half_period[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (read_error && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (phase_parse_en) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (req && (state != IDLE)) begin
      pending <= 1'b1;
    end else if (state == LOAD) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (state == LOAD) begin
      idx <= '0;
    end else if (txfifo_wr) begin
      idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_err <= '0;
      snap_frm <= '0;
      snap_mhp <= '0;
      snap_en  <= 1'b0;
      snap_chk <= '0;
    end else if (state == LOAD) begin
      snap_err <= err_cnt;
      snap_frm <= frame_cnt;
      snap_mhp <= mod_half_period;
      snap_en  <= mod_enable;
      snap_chk <= chk_live;
    end
  end

endmodule

// File: tb/tb_status_sender.sv
// Bench for status_sender: packet bytes go through a scoreboard queue,
// timing and corner cases are checked with explicit sequences.
module tb_status_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        clear_counts;
  logic        read_error;
  logic        phase_parse_en;
  logic        mod_enable;
  logic [15:0] mod_half_period;
  logic        txfifo_full;
  logic        txfifo_wr;
  logic [7:0]  txfifo_data;
  logic        busy;

  status_sender dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .clear_counts    (clear_counts),
    .read_error      (read_error),
    .phase_parse_en  (phase_parse_en),
    .mod_enable      (mod_enable),
    .mod_half_period (mod_half_period),
    .txfifo_full     (txfifo_full),
    .txfifo_wr       (txfifo_wr),
    .txfifo_data     (txfifo_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] mhp;
    int          n_err;
    int          n_frm;
    logic [7:0]  chk;
  } vec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         busy_n = 0;
  int         wcyc [64];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_n++;
    if (txfifo_wr === 1'b1) begin
      if (wr_cnt < 64) wcyc[wr_cnt] = cyc;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_write", {24'b0, txfifo_data}, 32'hxx);
      end else begin
        check("pkt_byte", {24'b0, txfifo_data},
              {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    wr_cnt = 0;
    busy_n = 0;
  endtask

  task automatic push_pkt(logic en, logic [15:0] mhp,
                          logic [15:0] err, logic [15:0] frm,
                          logic [7:0] chk);
    logic [7:0] b [14];
    b[0]  = 8'hA5;
    b[1]  = 8'h5A;
    b[2]  = 8'h00;
    b[3]  = 8'h01;
    b[4]  = 8'h00;
    b[5]  = 8'h80;
    b[6]  = err[15:8];
    b[7]  = err[7:0];
    b[8]  = frm[15:8];
    b[9]  = frm[7:0];
    b[10] = {7'b0, en};
    b[11] = mhp[15:8];
    b[12] = mhp[7:0];
    b[13] = chk;
    for (int i = 0; i < 14; i++) exp_q.push_back(b[i]);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic clear_cnt();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int n;
    n = 0;
    while (!(busy == 1'b0 && exp_q.size() == 0) && n < max) begin
      tick();
      n++;
    end
    check("idle_timeout", n < max, 1);
  endtask

  vec_t vecs [3];
  int   k;
  int   w;

  initial begin
    rst = 1'b1;
    req = 1'b0;
    clear_counts = 1'b0;
    read_error = 1'b0;
    phase_parse_en = 1'b0;
    mod_enable = 1'b0;
    mod_half_period = 16'h0;
    txfifo_full = 1'b0;
    tick();
    tick();
    check("rst_wr", txfifo_wr, 0);
    check("rst_data", txfifo_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{en: 1'b1, mhp: 16'h1234, n_err: 0, n_frm: 0,
                chk: 8'hA6};
    vecs[1] = '{en: 1'b0, mhp: 16'h0000, n_err: 2, n_frm: 5,
                chk: 8'h86};
    vecs[2] = '{en: 1'b1, mhp: 16'hFFFF, n_err: 1, n_frm: 0,
                chk: 8'h81};

    for (int v = 0; v < 3; v++) begin
      clear_cnt();
      read_error = 1'b1;
      repeat (vecs[v].n_err) tick();
      read_error = 1'b0;
      phase_parse_en = 1'b1;
      repeat (vecs[v].n_frm) tick();
      phase_parse_en = 1'b0;
      mod_enable = vecs[v].en;
      mod_half_period = vecs[v].mhp;
      push_pkt(vecs[v].en, vecs[v].mhp, 16'(vecs[v].n_err),
               16'(vecs[v].n_frm), vecs[v].chk);
      clr_stats();
      k = cyc;
      pulse_req();
      tick();
      mod_enable = ~vecs[v].en;
      mod_half_period = ~vecs[v].mhp;
      read_error = 1'b1;
      tick();
      read_error = 1'b0;
      wait_idle(100);
      check("vec_wr_cnt", wr_cnt, 14);
      check("vec_first_wr", wcyc[0], k + 2);
      check("vec_last_wr", wcyc[13], k + 15);
      check("vec_busy_cycles", busy_n, 15);
    end

    // backpressure after byte index 2
    clear_cnt();
    mod_enable = 1'b1;
    mod_half_period = 16'h1234;
    push_pkt(1'b1, 16'h1234, 16'h0, 16'h0, 8'hA6);
    clr_stats();
    k = cyc;
    pulse_req();
    for (int i = 0; i < 50 && wr_cnt < 3; i++) tick();
    check("bp_reach3", wr_cnt, 3);
    txfifo_full = 1'b1;
    tick();
    check("bp_wr_low", txfifo_wr, 0);
    repeat (4) tick();
    txfifo_full = 1'b0;
    wait_idle(100);
    check("bp_wr_cnt", wr_cnt, 14);
    check("bp_byte2_cyc", wcyc[2], k + 4);
    check("bp_byte3_cyc", wcyc[3], k + 10);
    check("bp_last_cyc", wcyc[13], k + 20);

    // saturation of err_cnt and wrap of frame_cnt
    clear_cnt();
    mod_enable = 1'b0;
    mod_half_period = 16'h0;
    read_error = 1'b1;
    phase_parse_en = 1'b1;
    repeat (65535) tick();
    read_error = 1'b0;
    phase_parse_en = 1'b0;
    push_pkt(1'b0, 16'h0, 16'hFFFF, 16'hFFFF, 8'h81);
    pulse_req();
    wait_idle(100);
    read_error = 1'b1;
    phase_parse_en = 1'b1;
    tick();
    read_error = 1'b0;
    phase_parse_en = 1'b0;
    push_pkt(1'b0, 16'h0, 16'hFFFF, 16'h0000, 8'h81);
    pulse_req();
    wait_idle(100);
    read_error = 1'b1;
    phase_parse_en = 1'b1;
    repeat (3) tick();
    read_error = 1'b0;
    phase_parse_en = 1'b0;
    push_pkt(1'b0, 16'h0, 16'hFFFF, 16'h0003, 8'h82);
    pulse_req();
    wait_idle(100);

    // clear beats a simultaneous increment
    clear_cnt();
    read_error = 1'b1;
    repeat (5) tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    read_error = 1'b0;
    mod_enable = 1'b1;
    mod_half_period = 16'h1234;
    push_pkt(1'b1, 16'h1234, 16'h0, 16'h0, 8'hA6);
    pulse_req();
    wait_idle(100);

    // three requests during SEND collapse into one more packet
    clear_cnt();
    mod_enable = 1'b0;
    mod_half_period = 16'h00AB;
    push_pkt(1'b0, 16'h00AB, 16'h0, 16'h0, 8'h2A);
    push_pkt(1'b0, 16'h00AB, 16'h0, 16'h0, 8'h2A);
    clr_stats();
    pulse_req();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      tick();
    end
    wait_idle(200);
    repeat (20) tick();
    check("col_wr_cnt", wr_cnt, 28);
    check("col_gap", wcyc[14] - wcyc[13], 3);

    // reset in the middle of a packet drops it and the pending request
    push_pkt(1'b0, 16'h00AB, 16'h0, 16'h0, 8'h2A);
    clr_stats();
    pulse_req();
    tick();
    pulse_req();
    for (int i = 0; i < 50 && wr_cnt < 5; i++) tick();
    check("rm_reach5", wr_cnt, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rm_wr", txfifo_wr, 0);
    check("rm_busy", busy, 0);
    w = wr_cnt;
    repeat (20) tick();
    check("rm_no_pending", wr_cnt, w);
    mod_enable = 1'b1;
    mod_half_period = 16'h1234;
    push_pkt(1'b1, 16'h1234, 16'h0, 16'h0, 8'hA6);
    pulse_req();
    wait_idle(100);
    check("rm_after_cnt", wr_cnt, w + 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
